// File: rtl/mdu_iter.sv
`default_nettype none
// ============================================================================
// Module   : mdu_iter
// Brief    : Iterative radix-2 multiply/divide unit writing a 2*WIDTH result
//            into HI/LO with a start/busy/done handshake and cancel.
//            Define MDU_ACC_EN to enable MADD/MADDU accumulation into {hi,lo}.
// Revision : 1.0
// ============================================================================
module mdu_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam int PW = 2 * WIDTH + 1;
    localparam logic [CW-1:0] c_iters = CW'(WIDTH);
    localparam logic [CW-1:0] c_one   = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [PW-1:0]    work_q, work_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] a_orig_q, a_orig_d;
    logic             div_q, div_d;
    logic             neg_q, neg_d;
    logic             rem_neg_q, rem_neg_d;
    logic             bz_q, bz_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             dz_q, dz_d;
    logic             done_q, done_d;
`ifdef MDU_ACC_EN
    logic             acc_q, acc_d;
`endif

    logic               w_legal;
    logic               w_signed;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [PW-1:0]      w_shl;
    logic [WIDTH:0]     w_try;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_mag2;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_res;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        work_d    = work_q;
        mcand_d   = mcand_q;
        a_orig_d  = a_orig_q;
        div_d     = div_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        bz_d      = bz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        dz_d      = dz_q;
        done_d    = 1'b0;
`ifdef MDU_ACC_EN
        acc_d     = acc_q;
        w_legal   = ~op[2] | (op[2:1] == 2'b10);
`else
        w_legal   = ~op[2];
`endif
        w_signed  = ~op[0];
        w_a_mag   = (w_signed && a[WIDTH-1]) ? -a : a;
        w_b_mag   = (w_signed && b[WIDTH-1]) ? -b : b;
        w_shl     = {work_q[PW-2:0], 1'b0};
        w_try     = w_shl[PW-1:WIDTH] - {1'b0, mcand_q};
        w_sum     = {1'b0, work_q[PW-2:WIDTH]}
                  + (work_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
        w_mag2    = work_q[PW-2:0];
        w_prod    = neg_q ? -w_mag2 : w_mag2;
        w_quo     = neg_q ? -work_q[WIDTH-1:0] : work_q[WIDTH-1:0];
        w_rem     = rem_neg_q ? -work_q[PW-2:WIDTH] : work_q[PW-2:WIDTH];
`ifdef MDU_ACC_EN
        w_res     = acc_q ? ({hi_q, lo_q} + w_prod) : w_prod;
`else
        w_res     = w_prod;
`endif

        case (state_q)
            S_IDLE: begin
                if (start && w_legal && !cancel) begin
                    state_d   = S_RUN;
                    cnt_d     = c_iters;
                    div_d     = op[1];
                    neg_d     = w_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                    rem_neg_d = w_signed & a[WIDTH-1];
                    bz_d      = (b == '0);
                    a_orig_d  = a;
                    // Divide shifts the dividend up into the remainder; multiply
                    // shifts the multiplier down while the product grows on top.
                    mcand_d   = op[1] ? w_b_mag : w_a_mag;
                    work_d    = {{(WIDTH+1){1'b0}}, op[1] ? w_a_mag : w_b_mag};
`ifdef MDU_ACC_EN
                    acc_d     = op[2];
`endif
                end
            end
            S_RUN: begin
                if (cancel) begin
                    state_d = S_IDLE;
                end else begin
                    if (div_q) begin
                        if (w_shl[PW-1:WIDTH] >= {1'b0, mcand_q}) begin
                            work_d = {w_try, w_shl[WIDTH-1:1], 1'b1};
                        end else begin
                            work_d = w_shl;
                        end
                    end else begin
                        work_d = {1'b0, w_sum, work_q[WIDTH-1:1]};
                    end
                    cnt_d = cnt_q - c_one;
                    if (cnt_q == c_one) begin
                        state_d = S_FIX;
                    end
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                if (!cancel) begin
                    done_d = 1'b1;
                    if (!div_q) begin
                        {hi_d, lo_d} = w_res;
                        dz_d         = 1'b0;
                    end else if (bz_q) begin
                        lo_d = '1;
                        hi_d = a_orig_q;
                        dz_d = 1'b1;
                    end else begin
                        lo_d = w_quo;
                        hi_d = w_rem;
                        dz_d = 1'b0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            work_q    <= '0;
            mcand_q   <= '0;
            a_orig_q  <= '0;
            div_q     <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            bz_q      <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            dz_q      <= 1'b0;
            done_q    <= 1'b0;
`ifdef MDU_ACC_EN
            acc_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            work_q    <= work_d;
            mcand_q   <= mcand_d;
            a_orig_q  <= a_orig_d;
            div_q     <= div_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            bz_q      <= bz_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            dz_q      <= dz_d;
            done_q    <= done_d;
`ifdef MDU_ACC_EN
            acc_q     <= acc_d;
`endif
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;
    assign hi       = hi_q;
    assign lo       = lo_q;
    assign div_zero = dz_q;

endmodule
`default_nettype wire

// File: tb/tb_mdu_iter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mdu_iter
// Brief    : Self-checking bench for mdu_iter (WIDTH=32) against an arithmetic
//            reference model; directed corner cases plus random operations.
// Revision : 1.0
// ============================================================================
module tb_mdu_iter;
    localparam int W = 32;

    logic         clock;
    logic         reset;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cancel;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         div_zero;

    int compared   = 0;
    int mismatched = 0;

    logic [W-1:0] m_hi;
    logic [W-1:0] m_lo;
    logic         m_dz;

    mdu_iter #(.WIDTH(W)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .cancel   (cancel),
        .busy     (busy),
        .done     (done),
        .hi       (hi),
        .lo       (lo),
        .div_zero (div_zero)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: whole-word arithmetic on 64-bit integers.
    function automatic void model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        longint sx, sy, q, r;
        logic [63:0] r64;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            3'b000, 3'b100: begin
                r64 = sx * sy;
                if (o[2]) r64 = r64 + {m_hi, m_lo};
                {m_hi, m_lo} = r64;
                m_dz = 1'b0;
            end
            3'b001, 3'b101: begin
                r64 = {32'b0, x} * {32'b0, y};
                if (o[2]) r64 = r64 + {m_hi, m_lo};
                {m_hi, m_lo} = r64;
                m_dz = 1'b0;
            end
            3'b010, 3'b011: begin
                if (y == 0) begin
                    m_lo = '1;
                    m_hi = x;
                    m_dz = 1'b1;
                end else if (o == 3'b010) begin
                    q = sx / sy;
                    r = sx % sy;
                    r64 = q;
                    m_lo = r64[31:0];
                    r64 = r;
                    m_hi = r64[31:0];
                    m_dz = 1'b0;
                end else begin
                    m_lo = x / y;
                    m_hi = x % y;
                    m_dz = 1'b0;
                end
            end
            default: ;
        endcase
    endfunction

    task automatic do_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input string tag);
        int n;
        bit busy_ok;
        @(negedge clock);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clock); #1;
        start = 1'b0;
        check({tag, ".busy_rise"}, 64'(busy), 64'd1);
        check({tag, ".done_low"}, 64'(done), 64'd0);
        model(o, x, y);
        n = 0;
        busy_ok = 1'b1;
        while (done !== 1'b1 && n < 100) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(posedge clock); #1;
            n++;
        end
        check({tag, ".latency"}, 64'(n), 64'(W + 1));
        check({tag, ".busy_held"}, 64'(busy_ok), 64'd1);
        check({tag, ".busy_fall"}, 64'(busy), 64'd0);
        check({tag, ".hilo"}, {hi, lo}, {m_hi, m_lo});
        check({tag, ".div_zero"}, 64'(div_zero), 64'(m_dz));
    endtask

    task automatic expect_idle(input string tag, input int cycles);
        int dones;
        int busys;
        dones = 0;
        busys = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clock); #1;
            if (done === 1'b1) dones++;
            if (busy === 1'b1) busys++;
        end
        check({tag, ".no_done"}, 64'(dones), 64'd0);
        check({tag, ".no_busy"}, 64'(busys), 64'd0);
        check({tag, ".hilo_hold"}, {hi, lo}, {m_hi, m_lo});
    endtask

    initial begin
        int n;
        logic [2:0]   ro;
        logic [W-1:0] ra, rb;

        reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0; cancel = 1'b0;
        m_hi = '0; m_lo = '0; m_dz = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("reset.busy", 64'(busy), 64'd0);
        check("reset.done", 64'(done), 64'd0);
        check("reset.hilo", {hi, lo}, 64'd0);
        check("reset.div_zero", 64'(div_zero), 64'd0);
        @(negedge clock);
        reset = 1'b0;

        do_op(3'b000, 32'hFFFF_FFFD, 32'd7, "mult_neg3x7");
        do_op(3'b011, 32'd100, 32'd7, "divu_100_7");
        do_op(3'b010, -32'sd7, 32'd2, "div_m7_2");
        do_op(3'b010, 32'd7, -32'sd2, "div_7_m2");
        do_op(3'b010, 32'd5, 32'd0, "div_by_zero");
        do_op(3'b001, 32'd3, 32'd4, "multu_after_dz");
        do_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, "div_overflow");
        do_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
        do_op(3'b011, 32'hFFFF_FFFF, 32'd0, "divu_by_zero");
        do_op(3'b000, 32'h8000_0000, 32'h8000_0000, "mult_min_min");

        // Mid-run start is ignored; cancel aborts with no write.
        @(negedge clock);
        start = 1'b1; op = 3'b000; a = 32'd1234; b = 32'd5678;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clock);
            start  = (c == 5);
            a      = (c == 5) ? 32'd99 : a;
            cancel = (c == 10);
            if (c == 9) check("cancel.busy_before", 64'(busy), 64'd1);
            if (c == 11) check("cancel.busy_after", 64'(busy), 64'd0);
        end
        expect_idle("cancel", 40);

        @(negedge clock);
        start = 1'b1; cancel = 1'b1; op = 3'b001; a = 32'd9; b = 32'd9;
        @(negedge clock);
        start = 1'b0; cancel = 1'b0;
        expect_idle("cancel_start_idle", 40);

        // Cancel in the final (write-back) cycle suppresses the write.
        @(negedge clock);
        start = 1'b1; op = 3'b001; a = 32'd11; b = 32'd13;
        @(posedge clock); #1;
        start = 1'b0;
        n = 0;
        while (n < W) begin
            @(posedge clock); #1;
            n++;
        end
        check("fix_cancel.busy_in_fix", 64'(busy), 64'd1);
        cancel = 1'b1;
        @(posedge clock); #1;
        cancel = 1'b0;
        check("fix_cancel.done", 64'(done), 64'd0);
        expect_idle("fix_cancel", 5);

`ifdef MDU_ACC_EN
        do_op(3'b001, 32'hFFFF_FFFF, 32'd1, "acc_setup");
        do_op(3'b101, 32'd1, 32'd1, "maddu_carry");
        do_op(3'b100, -32'sd3, 32'd5, "madd_neg");
`else
        for (int k = 4; k < 6; k++) begin
            @(negedge clock);
            start = 1'b1; op = 3'(k); a = 32'd1; b = 32'd1;
            @(negedge clock);
            start = 1'b0;
            expect_idle($sformatf("madd_disabled_%0d", k), 40);
        end
`endif
        for (int k = 6; k < 8; k++) begin
            @(negedge clock);
            start = 1'b1; op = 3'(k); a = 32'd7; b = 32'd3;
            @(negedge clock);
            start = 1'b0;
            expect_idle($sformatf("illegal_%0d", k), 40);
        end

        for (int t = 0; t < 24; t++) begin
`ifdef MDU_ACC_EN
            ro = 3'($urandom_range(0, 5));
`else
            ro = 3'($urandom_range(0, 3));
`endif
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if (t[0]) rb = rb >> $urandom_range(0, 28);
            do_op(ro, ra, rb, $sformatf("rand%0d_op%0d", t, ro));
        end

        // Asynchronous reset in the middle of a divide.
        @(negedge clock);
        start = 1'b1; op = 3'b010; a = 32'hDEAD_BEEF; b = 32'd17;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (10) @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset.busy", 64'(busy), 64'd0);
        check("async_reset.done", 64'(done), 64'd0);
        check("async_reset.hilo", {hi, lo}, 64'd0);
        check("async_reset.div_zero", 64'(div_zero), 64'd0);
        m_hi = '0; m_lo = '0; m_dz = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        expect_idle("after_reset", 40);
        do_op(3'b011, 32'd1000, 32'd33, "divu_after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
`default_nettype wire
